// File: rtl/eth_rx_frame_sched.sv
// Ping-pong frame buffer behind the RMII receive path: commits good-CRC frames into one of two
// slots and replays them in arrival order on a valid/ready byte stream.
module eth_rx_frame_sched #(
    parameter int pAddr_W = 11,
    parameter int pCnt_W  = 16
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic              Wr_Valid,
    input  logic [7:0]        Wr_Data,
    input  logic              Wr_Sof,
    input  logic              Wr_Eof,
    input  logic              Wr_Good,
    output logic              M_Valid,
    output logic [7:0]        M_Data,
    output logic              M_Last,
    input  logic              M_Ready,
    output logic [1:0]        Slots_Full,
    output logic [pCnt_W-1:0] Frame_Cnt,
    output logic [pCnt_W-1:0] Drop_Cnt,
    output logic [pCnt_W-1:0] Crc_Err_Cnt
);

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_DROP} wr_state_t;
    typedef enum logic [1:0] {R_IDLE, R_RD, R_OUT}    rd_state_t;

    localparam logic [pAddr_W:0]   OVF_CNT = {1'b1, {pAddr_W{1'b0}}};
    localparam logic [pAddr_W:0]   CNT_ONE = {{pAddr_W{1'b0}}, 1'b1};
    localparam logic [pAddr_W-1:0] OFF_ONE = {{(pAddr_W-1){1'b0}}, 1'b1};
    localparam logic [pCnt_W-1:0]  STAT_ONE = {{(pCnt_W-1){1'b0}}, 1'b1};

    function automatic logic [pCnt_W-1:0] sat_inc(input logic [pCnt_W-1:0] v);
        return (&v) ? v : v + STAT_ONE;
    endfunction

    wr_state_t          wr_state_q, wr_state_d;
    logic [pAddr_W:0]   wr_cnt_q, wr_cnt_d;
    logic               wr_ptr_q, wr_ptr_d;
    logic [pAddr_W:0]   len_q [2];
    logic [pAddr_W:0]   len_d [2];
    logic [1:0]         full_q, full_d, full_set, full_clr;
    logic [pCnt_W-1:0]  frame_cnt_q, frame_cnt_d;
    logic [pCnt_W-1:0]  drop_cnt_q, drop_cnt_d;
    logic [pCnt_W-1:0]  crc_err_cnt_q, crc_err_cnt_d;

    rd_state_t          rd_state_q, rd_state_d;
    logic               rd_ptr_q, rd_ptr_d;
    logic [pAddr_W-1:0] rd_off_q, rd_off_d;
    logic               m_valid_q, m_valid_d;
    logic [7:0]         m_data_q, m_data_d;
    logic               m_last_q, m_last_d;

    logic               mem_we, mem_re;
    logic [pAddr_W:0]   mem_waddr, mem_raddr;
    logic [7:0]         mem [2**(pAddr_W+1)];
    logic [7:0]         ram_rd_q;

    logic               resolve;
    logic [pAddr_W:0]   res_len;
    logic [pAddr_W-1:0] next_off;

    // Write side: a Sof beat always starts a new frame, whatever state the writer is in.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no path infers a latch.
        wr_state_d    = wr_state_q;
        wr_cnt_d      = wr_cnt_q;
        wr_ptr_d      = wr_ptr_q;
        len_d         = len_q;
        full_set      = '0;
        frame_cnt_d   = frame_cnt_q;
        drop_cnt_d    = drop_cnt_q;
        crc_err_cnt_d = crc_err_cnt_q;
        mem_we        = 1'b0;
        mem_waddr     = {wr_ptr_q, wr_cnt_q[pAddr_W-1:0]};
        resolve       = 1'b0;
        res_len       = wr_cnt_q + CNT_ONE;

        if (Wr_Valid) begin
            if (Wr_Sof) begin
                if (wr_state_q == W_DATA || full_q[wr_ptr_q]) begin
                    drop_cnt_d = sat_inc(drop_cnt_q);
                end
                if (full_q[wr_ptr_q]) begin
                    wr_state_d = Wr_Eof ? W_IDLE : W_DROP;
                end else begin
                    mem_we    = 1'b1;
                    mem_waddr = {wr_ptr_q, {pAddr_W{1'b0}}};
                    wr_cnt_d  = CNT_ONE;
                    wr_state_d = W_DATA;
                    resolve   = Wr_Eof;
                    res_len   = CNT_ONE;
                end
            end else begin
                case (wr_state_q)
                    W_DATA: begin
                        if (wr_cnt_q == OVF_CNT) begin
                            drop_cnt_d = sat_inc(drop_cnt_q);
                            wr_state_d = Wr_Eof ? W_IDLE : W_DROP;
                        end else begin
                            mem_we   = 1'b1;
                            wr_cnt_d = wr_cnt_q + CNT_ONE;
                            resolve  = Wr_Eof;
                        end
                    end
                    W_DROP: if (Wr_Eof) wr_state_d = W_IDLE;
                    default: ;
                endcase
            end
        end

        if (resolve) begin
            wr_state_d = W_IDLE;
            if (Wr_Good) begin
                full_set[wr_ptr_q] = 1'b1;
                len_d[wr_ptr_q]    = res_len;
                wr_ptr_d           = ~wr_ptr_q;
                frame_cnt_d        = sat_inc(frame_cnt_q);
            end else begin
                crc_err_cnt_d = sat_inc(crc_err_cnt_q);
            end
        end
    end

    // Read side: one RAM read per beat, output held until the consumer takes it.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_ptr_d   = rd_ptr_q;
        rd_off_d   = rd_off_q;
        m_valid_d  = m_valid_q;
        m_data_d   = m_data_q;
        m_last_d   = m_last_q;
        full_clr   = '0;
        mem_re     = 1'b0;
        next_off   = rd_off_q + OFF_ONE;
        mem_raddr  = {rd_ptr_q, rd_off_q};

        case (rd_state_q)
            R_IDLE: begin
                if (full_q[rd_ptr_q]) begin
                    mem_re     = 1'b1;
                    rd_off_d   = '0;
                    mem_raddr  = {rd_ptr_q, {pAddr_W{1'b0}}};
                    rd_state_d = R_RD;
                end
            end
            R_RD: begin
                m_data_d   = ram_rd_q;
                m_last_d   = ({1'b0, rd_off_q} == len_q[rd_ptr_q] - CNT_ONE);
                m_valid_d  = 1'b1;
                rd_state_d = R_OUT;
            end
            R_OUT: begin
                if (M_Ready) begin
                    m_valid_d = 1'b0;
                    if (m_last_q) begin
                        full_clr[rd_ptr_q] = 1'b1;
                        rd_ptr_d           = ~rd_ptr_q;
                        rd_state_d         = R_IDLE;
                    end else begin
                        rd_off_d   = next_off;
                        mem_re     = 1'b1;
                        mem_raddr  = {rd_ptr_q, next_off};
                        rd_state_d = R_RD;
                    end
                end
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    // Set and clear can never hit the same slot: commit needs it empty, release needs it full.
    assign full_d = (full_q | full_set) & ~full_clr;

    always_ff @(posedge Clk) begin
        // NOTE: sequential state uses <= so every flop samples pre-edge values.
        if (Rst) begin
            wr_state_q    <= W_IDLE;
            wr_cnt_q      <= '0;
            wr_ptr_q      <= 1'b0;
            len_q         <= '{default: '0};
            full_q        <= '0;
            frame_cnt_q   <= '0;
            drop_cnt_q    <= '0;
            crc_err_cnt_q <= '0;
            rd_state_q    <= R_IDLE;
            rd_ptr_q      <= 1'b0;
            rd_off_q      <= '0;
            m_valid_q     <= 1'b0;
            m_data_q      <= '0;
            m_last_q      <= 1'b0;
        end else begin
            wr_state_q    <= wr_state_d;
            wr_cnt_q      <= wr_cnt_d;
            wr_ptr_q      <= wr_ptr_d;
            len_q         <= len_d;
            full_q        <= full_d;
            frame_cnt_q   <= frame_cnt_d;
            drop_cnt_q    <= drop_cnt_d;
            crc_err_cnt_q <= crc_err_cnt_d;
            rd_state_q    <= rd_state_d;
            rd_ptr_q      <= rd_ptr_d;
            rd_off_q      <= rd_off_d;
            m_valid_q     <= m_valid_d;
            m_data_q      <= m_data_d;
            m_last_q      <= m_last_d;
        end
    end

    // NOTE: the frame RAM has no reset; a slot is only read after its bytes were written.
    always_ff @(posedge Clk) begin
        if (mem_we) mem[mem_waddr] <= Wr_Data;
        if (mem_re) ram_rd_q <= mem[mem_raddr];
    end

    assign M_Valid     = m_valid_q;
    assign M_Data      = m_data_q;
    assign M_Last      = m_last_q;
    assign Slots_Full  = full_q;
    assign Frame_Cnt   = frame_cnt_q;
    assign Drop_Cnt    = drop_cnt_q;
    assign Crc_Err_Cnt = crc_err_cnt_q;

endmodule

// File: tb/tb_eth_rx_frame_sched.sv
// Directed bench for eth_rx_frame_sched: a frame table for streaming/counter behaviour plus
// hand sequences for latency, back-pressure, abort and reset corner cases.
module tb_eth_rx_frame_sched;

    logic        Clk, Rst;
    logic        Wr_Valid, Wr_Sof, Wr_Eof, Wr_Good;
    logic [7:0]  Wr_Data;
    logic        M_Valid, M_Last, M_Ready;
    logic [7:0]  M_Data;
    logic [1:0]  Slots_Full;
    logic [15:0] Frame_Cnt, Drop_Cnt, Crc_Err_Cnt;

    eth_rx_frame_sched #(.pAddr_W(11), .pCnt_W(16)) dut (
        .Clk(Clk), .Rst(Rst),
        .Wr_Valid(Wr_Valid), .Wr_Data(Wr_Data), .Wr_Sof(Wr_Sof), .Wr_Eof(Wr_Eof), .Wr_Good(Wr_Good),
        .M_Valid(M_Valid), .M_Data(M_Data), .M_Last(M_Last), .M_Ready(M_Ready),
        .Slots_Full(Slots_Full), .Frame_Cnt(Frame_Cnt), .Drop_Cnt(Drop_Cnt), .Crc_Err_Cnt(Crc_Err_Cnt)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int checks = 0;
    int failures = 0;
    logic [8:0] rx_q [$];

    // Accepted beats are captured on the falling edge, half a cycle before the accepting edge.
    always @(negedge Clk) begin
        if (!Rst && M_Valid && M_Ready) rx_q.push_back({M_Last, M_Data});
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] d, input bit sof, input bit eof, input bit good);
        Wr_Valid = 1'b1; Wr_Data = d; Wr_Sof = sof; Wr_Eof = eof; Wr_Good = good;
        @(posedge Clk); #1;
        Wr_Valid = 1'b0; Wr_Sof = 1'b0; Wr_Eof = 1'b0; Wr_Good = 1'b0;
    endtask

    // One byte every four clocks; returns 1 time unit after the edge that took the last byte.
    task automatic send_frame(input int len, input bit good, input int base, input bit do_eof);
        for (int i = 0; i < len; i++) begin
            if (i > 0) repeat (3) begin @(posedge Clk); #1; end
            send_byte(8'((base + i) & 255), i == 0, do_eof && (i == len - 1), good);
        end
    endtask

    task automatic check_frame(input string name, input int len, input int base);
        int t;
        int bad;
        logic [8:0] exp;
        t = 0;
        while (rx_q.size() < len && t < len * 4 + 100) begin
            @(posedge Clk);
            t++;
        end
        #1;
        check({name, "_beats"}, rx_q.size(), len);
        bad = 0;
        for (int i = 0; i < len && i < rx_q.size(); i++) begin
            exp = {(i == len - 1), 8'((base + i) & 255)};
            if (rx_q[i] !== exp) bad++;
        end
        check({name, "_data_errs"}, bad, 0);
        for (int i = 0; i < len && rx_q.size() > 0; i++) void'(rx_q.pop_front());
    endtask

    task automatic do_reset();
        Rst = 1'b1;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        rx_q.delete();
    endtask

    typedef struct {
        int len;
        bit good;
        int base;
        bit exp_out;
        int exp_frame;
        int exp_drop;
        int exp_crc;
    } vec_t;

    vec_t vecs [8];

    initial begin
        // Counter expectations are cumulative from the reset before the table.
        vecs[0] = '{64,   1'b1, 'h00, 1'b1, 1, 0, 0};
        vecs[1] = '{60,   1'b0, 'h40, 1'b0, 1, 0, 1};
        vecs[2] = '{60,   1'b1, 'h80, 1'b1, 2, 0, 1};
        vecs[3] = '{1,    1'b1, 'h5A, 1'b1, 3, 0, 1};
        vecs[4] = '{2049, 1'b1, 'h10, 1'b0, 3, 1, 1};
        vecs[5] = '{1,    1'b1, 'hA5, 1'b1, 4, 1, 1};
        vecs[6] = '{2048, 1'b1, 'h33, 1'b1, 5, 1, 1};
        vecs[7] = '{1,    1'b0, 'h77, 1'b0, 5, 1, 2};

        Rst = 1'b1; Wr_Valid = 1'b0; Wr_Data = '0; Wr_Sof = 1'b0; Wr_Eof = 1'b0; Wr_Good = 1'b0;
        M_Ready = 1'b1;
        do_reset();

        check("rst_m_valid", M_Valid, 0);
        check("rst_m_data", M_Data, 0);
        check("rst_m_last", M_Last, 0);
        check("rst_slots", Slots_Full, 0);
        check("rst_counters", {Frame_Cnt | Drop_Cnt | Crc_Err_Cnt}, 0);

        // First M_Valid lands two edges after the edge that took the Eof beat.
        send_frame(8, 1'b1, 'hC0, 1'b1);
        check("lat_e0_valid", M_Valid, 0);
        @(posedge Clk); #1;
        check("lat_e1_valid", M_Valid, 0);
        @(posedge Clk); #1;
        check("lat_e2_valid", M_Valid, 1);
        check("lat_e2_data", M_Data, 'hC0);
        check_frame("lat", 8, 'hC0);

        do_reset();
        for (int v = 0; v < 8; v++) begin
            send_frame(vecs[v].len, vecs[v].good, vecs[v].base, 1'b1);
            if (vecs[v].exp_out) begin
                check_frame($sformatf("v%0d", v), vecs[v].len, vecs[v].base);
            end else begin
                repeat (20) @(posedge Clk);
                #1;
                check($sformatf("v%0d_no_output", v), rx_q.size(), 0);
            end
            repeat (4) @(posedge Clk);
            #1;
            check($sformatf("v%0d_frame_cnt", v), Frame_Cnt, vecs[v].exp_frame);
            check($sformatf("v%0d_drop_cnt", v), Drop_Cnt, vecs[v].exp_drop);
            check($sformatf("v%0d_crc_cnt", v), Crc_Err_Cnt, vecs[v].exp_crc);
            check($sformatf("v%0d_slots", v), Slots_Full, 0);
        end

        // Consumer stalled: two frames fill both slots, the third has nowhere to go.
        do_reset();
        M_Ready = 1'b0;
        send_frame(16, 1'b1, 'h10, 1'b1);
        repeat (4) begin @(posedge Clk); #1; end
        check("bp_slots_a", Slots_Full, 2'b01);
        check("bp_a_valid", M_Valid, 1);
        send_frame(8, 1'b1, 'h20, 1'b1);
        repeat (4) begin @(posedge Clk); #1; end
        check("bp_slots_ab", Slots_Full, 2'b11);
        send_frame(5, 1'b1, 'h30, 1'b1);
        repeat (4) begin @(posedge Clk); #1; end
        check("bp_slots_abc", Slots_Full, 2'b11);
        check("bp_drop_cnt", Drop_Cnt, 1);
        check("bp_frame_cnt", Frame_Cnt, 2);
        check("bp_hold_valid", M_Valid, 1);
        check("bp_hold_data", M_Data, 'h10);
        check("bp_hold_last", M_Last, 0);
        M_Ready = 1'b1;
        check_frame("bp_a", 16, 'h10);
        check_frame("bp_b", 8, 'h20);
        repeat (20) @(posedge Clk);
        #1;
        check("bp_no_c", rx_q.size(), 0);
        check("bp_slots_empty", Slots_Full, 0);

        // A new Sof ten bytes into a frame aborts it; the new frame must arrive intact.
        do_reset();
        send_frame(10, 1'b1, 'h40, 1'b0);
        repeat (3) begin @(posedge Clk); #1; end
        send_frame(20, 1'b1, 'h60, 1'b1);
        check_frame("abort_b", 20, 'h60);
        check("abort_drop_cnt", Drop_Cnt, 1);
        check("abort_frame_cnt", Frame_Cnt, 1);
        check("abort_crc_cnt", Crc_Err_Cnt, 0);

        // Reset while a byte is presented, then normal operation resumes.
        do_reset();
        M_Ready = 1'b0;
        send_frame(12, 1'b1, 'h90, 1'b1);
        for (int t = 0; t < 20 && !M_Valid; t++) begin @(posedge Clk); #1; end
        check("rst_mid_valid_before", M_Valid, 1);
        Rst = 1'b1;
        @(posedge Clk); #1;
        check("rst_mid_valid", M_Valid, 0);
        check("rst_mid_data", M_Data, 0);
        check("rst_mid_last", M_Last, 0);
        check("rst_mid_slots", Slots_Full, 0);
        check("rst_mid_frame_cnt", Frame_Cnt, 0);
        Rst = 1'b0;
        rx_q.delete();
        M_Ready = 1'b1;
        send_frame(7, 1'b1, 'hD0, 1'b1);
        check_frame("rst_after", 7, 'hD0);
        repeat (4) @(posedge Clk);
        #1;
        check("rst_after_frame_cnt", Frame_Cnt, 1);
        check("rst_after_slots", Slots_Full, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
